// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters and the register file write port.
// The master side holds both requesters and observes the register file port.
interface regfile_wb_arbiter_if;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  logic              req0_valid;
  logic              req0_ready;
  logic [RD_W-1:0]   req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [RD_W-1:0]   req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              rf_reg_write;
  logic [RD_W-1:0]   rf_rd;
  logic [DATA_W-1:0] rf_data;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  rf_reg_write, rf_rd, rf_data
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output rf_reg_write, rf_rd, rf_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU/jump result (port 0)
// and returning load data (port 1); registered write stage, x0 suppression, conflict counter.
module regfile_wb_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb,
  output logic                 last_grant,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic grant0_c;
  logic grant1_c;
  logic accept0_c;
  logic accept1_c;
  logic conflict_c;

  // Grant selection: a lone requester always wins; on conflict, priority or round-robin.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (wb.req0_valid && wb.req1_valid) begin
      if ((PRIORITY_MODE == 1) || last_grant) begin
        grant0_c = 1'b1;
      end else begin
        grant1_c = 1'b1;
      end
    end else begin
      grant0_c = wb.req0_valid;
      grant1_c = wb.req1_valid;
    end
  end

  // Readies are held low during reset so no handshake can complete.
  assign wb.req0_ready = grant0_c & ~reset;
  assign wb.req1_ready = grant1_c & ~reset;

  assign accept0_c  = wb.req0_valid & wb.req0_ready;
  assign accept1_c  = wb.req1_valid & wb.req1_ready;
  assign conflict_c = wb.req0_valid & wb.req1_valid;

  // Write stage: rd/data captured on every accept, enable only for non-x0 targets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb.rf_reg_write <= 1'b0;
      wb.rf_rd        <= '0;
      wb.rf_data      <= '0;
      last_grant      <= 1'b1;
    end else begin
      wb.rf_reg_write <= 1'b0;
      if (accept0_c) begin
        wb.rf_reg_write <= (wb.req0_rd != '0);
        wb.rf_rd        <= wb.req0_rd;
        wb.rf_data      <= wb.req0_data;
        last_grant      <= 1'b0;
      end else if (accept1_c) begin
        wb.rf_reg_write <= (wb.req1_rd != '0);
        wb.rf_rd        <= wb.req1_rd;
        wb.rf_data      <= wb.req1_data;
        last_grant      <= 1'b1;
      end
    end
  end

  // Saturating count of cycles with both requesters contending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (conflict_c && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: round-robin, fixed-priority and narrow-counter instances.
// Stimulus pushes expected register file writes; per-instance monitors pop on each write pulse.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        lgA, lgB, lgC;
  logic [15:0] cntA, cntB;
  logic [3:0]  cntC;

  int tests = 0;
  int fails = 0;

  wr_t qA[$];
  wr_t qB[$];
  wr_t qC[$];

  regfile_wb_arbiter_if ifA ();
  regfile_wb_arbiter_if ifB ();
  regfile_wb_arbiter_if ifC ();

  regfile_wb_arbiter #(.PRIORITY_MODE(0), .CNT_W(16)) dutA (
    .clk(clk), .reset(reset), .wb(ifA.slave), .last_grant(lgA), .conflict_cnt(cntA));
  regfile_wb_arbiter #(.PRIORITY_MODE(1), .CNT_W(16)) dutB (
    .clk(clk), .reset(reset), .wb(ifB.slave), .last_grant(lgB), .conflict_cnt(cntB));
  regfile_wb_arbiter #(.PRIORITY_MODE(0), .CNT_W(4)) dutC (
    .clk(clk), .reset(reset), .wb(ifC.slave), .last_grant(lgC), .conflict_cnt(cntC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: handshake legality every cycle, scoreboard pop on every write pulse.
  always @(negedge clk) begin : monA
    wr_t e;
    chk("A_ready_without_valid", 32'((ifA.req0_ready & ~ifA.req0_valid) | (ifA.req1_ready & ~ifA.req1_valid)), 0);
    chk("A_both_ready", 32'(ifA.req0_ready & ifA.req1_ready), 0);
    if (ifA.rf_reg_write) begin
      chk("A_write_expected", 32'(qA.size() != 0), 1);
      if (qA.size() != 0) begin
        e = qA.pop_front();
        chk("A_wr_rd", 32'(ifA.rf_rd), 32'(e.rd));
        chk("A_wr_data", ifA.rf_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : monB
    wr_t e;
    chk("B_ready_without_valid", 32'((ifB.req0_ready & ~ifB.req0_valid) | (ifB.req1_ready & ~ifB.req1_valid)), 0);
    chk("B_both_ready", 32'(ifB.req0_ready & ifB.req1_ready), 0);
    if (ifB.rf_reg_write) begin
      chk("B_write_expected", 32'(qB.size() != 0), 1);
      if (qB.size() != 0) begin
        e = qB.pop_front();
        chk("B_wr_rd", 32'(ifB.rf_rd), 32'(e.rd));
        chk("B_wr_data", ifB.rf_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : monC
    wr_t e;
    chk("C_ready_without_valid", 32'((ifC.req0_ready & ~ifC.req0_valid) | (ifC.req1_ready & ~ifC.req1_valid)), 0);
    chk("C_both_ready", 32'(ifC.req0_ready & ifC.req1_ready), 0);
    if (ifC.rf_reg_write) begin
      chk("C_write_expected", 32'(qC.size() != 0), 1);
      if (qC.size() != 0) begin
        e = qC.pop_front();
        chk("C_wr_rd", 32'(ifC.rf_rd), 32'(e.rd));
        chk("C_wr_data", ifC.rf_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected to have finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1;
    ifA.req0_valid = 1'b0; ifA.req0_rd = '0; ifA.req0_data = '0;
    ifA.req1_valid = 1'b0; ifA.req1_rd = '0; ifA.req1_data = '0;
    ifB.req0_valid = 1'b0; ifB.req0_rd = '0; ifB.req0_data = '0;
    ifB.req1_valid = 1'b0; ifB.req1_rd = '0; ifB.req1_data = '0;
    ifC.req0_valid = 1'b0; ifC.req0_rd = '0; ifC.req0_data = '0;
    ifC.req1_valid = 1'b0; ifC.req1_rd = '0; ifC.req1_data = '0;
    step();
    step();

    // Reset state, with a valid request that must not be readied
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd1; ifA.req0_data = 32'h1;
    @(negedge clk);
    chk("rst_ready0", 32'(ifA.req0_ready), 0);
    chk("rst_rf_reg_write", 32'(ifA.rf_reg_write), 0);
    chk("rst_rf_rd", 32'(ifA.rf_rd), 0);
    chk("rst_rf_data", ifA.rf_data, 0);
    chk("rst_last_grant_A", 32'(lgA), 1);
    chk("rst_last_grant_B", 32'(lgB), 1);
    chk("rst_last_grant_C", 32'(lgC), 1);
    chk("rst_conflict_cnt", 32'(cntA), 0);
    step();
    ifA.req0_valid = 1'b0;
    reset = 1'b0;

    // Single-port write
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd5; ifA.req0_data = 32'h0000_00FC;
    qA.push_back(wr_t'{rd: 5'd5, data: 32'h0000_00FC});
    @(negedge clk);
    chk("single_ready0", 32'(ifA.req0_ready), 1);
    chk("single_ready1", 32'(ifA.req1_ready), 0);
    step();
    ifA.req0_valid = 1'b0;
    @(negedge clk);
    chk("single_rf_reg_write", 32'(ifA.rf_reg_write), 1);
    chk("single_rf_rd", 32'(ifA.rf_rd), 5);
    chk("single_rf_data", ifA.rf_data, 32'hFC);
    chk("single_last_grant", 32'(lgA), 0);
    step();
    @(negedge clk);
    chk("single_pulse_end", 32'(ifA.rf_reg_write), 0);
    chk("single_rd_hold", 32'(ifA.rf_rd), 5);

    // Asynchronous reset in the cycle after an accept discards that write
    step();
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd7; ifA.req0_data = 32'h77;
    ifA.req1_valid = 1'b1; ifA.req1_rd = 5'd8; ifA.req1_data = 32'h88;
    @(posedge clk);
    #1;
    ifA.req1_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_rf_reg_write", 32'(ifA.rf_reg_write), 0);
    chk("midrst_rf_rd", 32'(ifA.rf_rd), 0);
    chk("midrst_rf_data", ifA.rf_data, 0);
    chk("midrst_last_grant", 32'(lgA), 1);
    chk("midrst_conflict_cnt", 32'(cntA), 0);
    chk("midrst_ready0", 32'(ifA.req0_ready), 0);
    step();
    reset = 1'b0;
    ifA.req0_valid = 1'b0;

    // Round-robin conflict after reset: port 0 first, then port 1
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd3; ifA.req0_data = 32'h11;
    ifA.req1_valid = 1'b1; ifA.req1_rd = 5'd4; ifA.req1_data = 32'h22;
    qA.push_back(wr_t'{rd: 5'd3, data: 32'h11});
    qA.push_back(wr_t'{rd: 5'd4, data: 32'h22});
    @(negedge clk);
    chk("rr_c1_ready0", 32'(ifA.req0_ready), 1);
    chk("rr_c1_ready1", 32'(ifA.req1_ready), 0);
    step();
    ifA.req0_valid = 1'b0;
    @(negedge clk);
    chk("rr_c2_ready0", 32'(ifA.req0_ready), 0);
    chk("rr_c2_ready1", 32'(ifA.req1_ready), 1);
    chk("rr_c2_rf_rd", 32'(ifA.rf_rd), 3);
    step();
    ifA.req1_valid = 1'b0;
    @(negedge clk);
    chk("rr_rf_reg_write", 32'(ifA.rf_reg_write), 1);
    chk("rr_rf_rd", 32'(ifA.rf_rd), 4);
    chk("rr_conflict_cnt", 32'(cntA), 1);
    chk("rr_last_grant", 32'(lgA), 1);

    // x0 suppression on port 1, preceded by a port 0 write so last_grant visibly moves
    step();
    ifA.req0_valid = 1'b1; ifA.req0_rd = 5'd9; ifA.req0_data = 32'h99;
    qA.push_back(wr_t'{rd: 5'd9, data: 32'h99});
    @(negedge clk);
    chk("x0_pre_ready0", 32'(ifA.req0_ready), 1);
    step();
    ifA.req0_valid = 1'b0;
    ifA.req1_valid = 1'b1; ifA.req1_rd = 5'd0; ifA.req1_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("x0_ready1", 32'(ifA.req1_ready), 1);
    chk("x0_pre_last_grant", 32'(lgA), 0);
    step();
    ifA.req1_valid = 1'b0;
    @(negedge clk);
    chk("x0_rf_reg_write", 32'(ifA.rf_reg_write), 0);
    chk("x0_last_grant", 32'(lgA), 1);
    chk("x0_rf_rd", 32'(ifA.rf_rd), 0);
    chk("x0_rf_data", ifA.rf_data, 32'hDEAD_BEEF);

    // Fixed priority: port 0 wins every contended cycle
    step();
    ifB.req0_valid = 1'b1;
    ifB.req1_valid = 1'b1; ifB.req1_rd = 5'd2; ifB.req1_data = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      ifB.req0_rd   = 5'(i + 1);
      ifB.req0_data = 32'hA0 + 32'(i);
      qB.push_back(wr_t'{rd: 5'(i + 1), data: 32'hA0 + 32'(i)});
      @(negedge clk);
      chk("prio_ready0", 32'(ifB.req0_ready), 1);
      chk("prio_ready1", 32'(ifB.req1_ready), 0);
      step();
    end
    ifB.req0_valid = 1'b0;
    qB.push_back(wr_t'{rd: 5'd2, data: 32'hB2});
    @(negedge clk);
    chk("prio_ready1_after", 32'(ifB.req1_ready), 1);
    chk("prio_ready0_after", 32'(ifB.req0_ready), 0);
    chk("prio_conflict_cnt", 32'(cntB), 3);
    step();
    ifB.req1_valid = 1'b0;
    @(negedge clk);
    chk("prio_conflict_cnt_hold", 32'(cntB), 3);
    chk("prio_last_grant", 32'(lgB), 1);

    // Saturation on a 4-bit counter with alternating grants
    step();
    ifC.req0_valid = 1'b1; ifC.req0_rd = 5'd10;
    ifC.req1_valid = 1'b1; ifC.req1_rd = 5'd11;
    for (int i = 0; i < 20; i++) begin
      if ((i % 2) == 0) begin
        ifC.req0_data = 32'hC00 + 32'(i);
        ifC.req1_data = 32'hD00 + 32'(i + 1);
        qC.push_back(wr_t'{rd: 5'd10, data: 32'hC00 + 32'(i)});
      end else begin
        qC.push_back(wr_t'{rd: 5'd11, data: 32'hD00 + 32'(i)});
      end
      @(negedge clk);
      chk("sat_ready0", 32'(ifC.req0_ready), 32'((i % 2) == 0));
      chk("sat_conflict_cnt", 32'(cntC), (i > 15) ? 32'd15 : 32'(i));
      step();
    end
    ifC.req0_valid = 1'b0;
    ifC.req1_valid = 1'b0;
    @(negedge clk);
    chk("sat_cnt_final", 32'(cntC), 15);
    chk("sat_last_grant", 32'(lgC), 1);
    step();
    step();
    @(negedge clk);
    chk("sat_cnt_idle", 32'(cntC), 15);

    step();
    @(negedge clk);
    chk("A_queue_drained", 32'(qA.size()), 0);
    chk("B_queue_drained", 32'(qB.size()), 0);
    chk("C_queue_drained", 32'(qC.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (write-enable, 5-bit write address, 32-bit write data) between two writeback requesters: port 0 (ALU/jump result) and port 1 (load data returning from data memory).
- Uses valid/ready handshakes, round-robin or fixed-priority arbitration, and a registered write-port output stage.
- Suppresses writes to x0 and keeps a saturating count of arbitration conflicts.
- Sits between the execute/memory stages and the register file.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  port 0 has a write pending.
- req0_ready  output  1  port 0 write accepted this cycle.
- req0_rd  input  5  port 0 destination register.
- req0_data  input  32  port 0 write data.
- req1_valid  input  1  port 1 has a write pending.
- req1_ready  output  1  port 1 write accepted this cycle.
- req1_rd  input  5  port 1 destination register.
- req1_data  input  32  port 1 write data.
- rf_reg_write  output  1  register file write enable.
- rf_rd  output  5  register file write address.
- rf_data  output  32  register file write data.
- last_grant  output  1  port granted in the most recent accepted handshake.
- conflict_cnt  output  CNT_W  cycles in which both valids were high.

Behaviour:
- Reset (asynchronous, active-high), effective immediately:
  - rf_reg_write=0, rf_rd=0, rf_data=0.
  - last_grant=1, so port 0 wins the first conflict.
  - conflict_cnt=0.
  - req0_ready=0 and req1_ready=0 while reset is high.
- Reset mid-operation discards any registered write not yet presented; no handshake completes while reset is high.
- Ready logic: combinational from the valids and last_grant. At most one ready is high per cycle. A ready is never high unless its valid is high.
  - Only one valid high: that port gets ready.
  - Both high, PRIORITY_MODE=0: grant the port != last_grant.
  - Both high, PRIORITY_MODE=1: grant port 0.
- Accept = valid & ready on a posedge. The losing requester holds valid, rd and data stable until accepted; the bench checks this, the block does not.
- Output stage, latency 1: on an accept at edge N, at edge N the block registers rf_rd=rd and rf_data=data. During cycle N+1, rf_reg_write=1 if rd!=0, else 0.
- With no accept at edge N, rf_reg_write=0 in cycle N+1. rf_rd and rf_data hold their last values.
- x0 suppression: rd=0 is still accepted (ready asserted, handshake completes, last_grant updates), but rf_reg_write stays 0.
- Throughput: one accept per cycle, no bubbles. Back-to-back accepts give consecutive rf_reg_write pulses.
- last_grant updates on every accept to the accepted port index; it is unchanged on idle cycles.
- conflict_cnt increments on every posedge with req0_valid & req1_valid (reset low). It saturates at 2^CNT_W-1 and does not wrap.
- Same-rd conflict (both valid, equal rd): no special handling. Arbitration order decides, and the later write wins in the register file.
- There is no internal queue. Back-pressure comes only through ready.

Test Plan:
- Reset sequence: assert reset asynchronously mid-cycle with req0_valid=1 -> all outputs return to their reset values immediately, no rf_reg_write pulse follows, last_grant=1, conflict_cnt=0.
- Single-port write: req0_valid=1, rd=5, data=0x0000_00FC for 1 cycle -> req0_ready=1 that cycle; next cycle rf_reg_write=1, rf_rd=5, rf_data=0xFC; the cycle after, rf_reg_write=0.
- Round-robin conflict, PRIORITY_MODE=0, after reset:
  - Stimulus: both valid for 2 cycles, req0 (rd=3, 0x11), req1 (rd=4, 0x22), each dropping valid once accepted.
  - Response: port 0 accepted first, then port 1; rf writes reg3=0x11, then reg4=0x22 on consecutive cycles; conflict_cnt=1; last_grant=1.
- Fixed priority, PRIORITY_MODE=1:
  - Stimulus: both valid and held for 3 cycles.
  - Response: req0_ready=1 every cycle; req1_ready stays 0 until req0_valid drops; conflict_cnt=3.
- x0 suppression: req1_valid=1, rd=0, data=0xDEADBEEF -> req1_ready=1; next cycle rf_reg_write=0; last_grant=1.
- Saturation: CNT_W=4, both valid and alternately accepted for 20 cycles -> conflict_cnt stops at 15 and stays at 15.
